// File: rtl/cfu_arbiter.sv
// cfu_arbiter: shares one multi-cycle CFU between two requesters.
// Port 0 is the CPU execute stage, port 1 the debug/DMA test port.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   rN_valid_i/rN_ready_o   request handshake (ready combinational)
//   rN_ctrl_i/src1_i/src2_i request payload, sampled at handshake
//   rN_rvalid_o/rslt_o/err_o one-cycle response to the granted port
//   cfu_en_o/ctrl_o/src*_o  issue pulse and held operands to the CFU
//   cfu_stall_i/cfu_rslt_i  CFU busy flag and result
//
// Optional feature: define CFU_ARB_TIMEOUT_EN to abort a WAIT that
// stalls for TIMEOUT_CYCLES cycles (result 0, err flag set).
module cfu_arbiter #(
    parameter bit RESET_LAST     = 1'b1,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        r0_valid_i,
    output logic        r0_ready_o,
    input  logic [9:0]  r0_ctrl_i,
    input  logic [31:0] r0_src1_i,
    input  logic [31:0] r0_src2_i,
    output logic        r0_rvalid_o,
    output logic [31:0] r0_rslt_o,
    output logic        r0_err_o,
    input  logic        r1_valid_i,
    output logic        r1_ready_o,
    input  logic [9:0]  r1_ctrl_i,
    input  logic [31:0] r1_src1_i,
    input  logic [31:0] r1_src2_i,
    output logic        r1_rvalid_o,
    output logic [31:0] r1_rslt_o,
    output logic        r1_err_o,
    output logic        cfu_en_o,
    output logic [9:0]  cfu_ctrl_o,
    output logic [31:0] cfu_src1_o,
    output logic [31:0] cfu_src2_o,
    input  logic        cfu_stall_i,
    input  logic [31:0] cfu_rslt_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cfu_arbiter: TIMEOUT_CYCLES must be 2..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last;
    logic        gnt_id;
    logic [9:0]  ctrl_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] r0_rslt_q;
    logic [31:0] r1_rslt_q;
    logic        sel0;
    logic        sel1;
    logic        take;
    logic        finish;
    logic        timeout;

    // On a tie, the port that was not served last wins.
    assign sel0 = r0_valid_i & (~r1_valid_i | last);
    assign sel1 = r1_valid_i & (~r0_valid_i | ~last);
    assign take = (state == IDLE) & (sel0 | sel1);

    // While reset is held the FSM sits in IDLE; keep ready low anyway.
    assign r0_ready_o = (state == IDLE) & sel0 & ~rst_i;
    assign r1_ready_o = (state == IDLE) & sel1 & ~rst_i;

    assign finish = (state == WAIT) & (~cfu_stall_i | timeout);

`ifdef CFU_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic        err_q;

    // Abort on the stalled WAIT cycle that brings the count to the limit.
    assign timeout = (state == WAIT) & cfu_stall_i & (wait_cnt == TO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT && cfu_stall_i) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (finish) begin
                err_q <= timeout;
            end
        end
    end

    assign r0_err_o = r0_rvalid_o & err_q;
    assign r1_err_o = r1_rvalid_o & err_q;
`else
    assign timeout  = 1'b0;
    assign r0_err_o = 1'b0;
    assign r1_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            last      <= RESET_LAST;
            gnt_id    <= 1'b0;
            ctrl_q    <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            r0_rslt_q <= '0;
            r1_rslt_q <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                gnt_id <= sel1;
                ctrl_q <= sel1 ? r1_ctrl_i : r0_ctrl_i;
                src1_q <= sel1 ? r1_src1_i : r0_src1_i;
                src2_q <= sel1 ? r1_src2_i : r0_src2_i;
            end
            if (finish) begin
                if (gnt_id) begin
                    r1_rslt_q <= timeout ? '0 : cfu_rslt_i;
                end else begin
                    r0_rslt_q <= timeout ? '0 : cfu_rslt_i;
                end
            end
            if (state == RESP) begin
                last <= gnt_id;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cfu_en_o   = (state == ISSUE);
    assign cfu_ctrl_o = ctrl_q;
    assign cfu_src1_o = src1_q;
    assign cfu_src2_o = src2_q;

    assign r0_rvalid_o = (state == RESP) & ~gnt_id;
    assign r1_rvalid_o = (state == RESP) & gnt_id;
    assign r0_rslt_o   = r0_rslt_q;
    assign r1_rslt_o   = r1_rslt_q;

endmodule

// File: tb/tb_cfu_arbiter.sv
// tb_cfu_arbiter: directed table-driven bench for cfu_arbiter with a
// behavioural CFU (add, or subtract when ctrl==1) of programmable stall.
module tb_cfu_arbiter;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [9:0]  c0;
        logic [9:0]  c1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        int          stall;
        int          lat;
        logic        gnt;
        logic [31:0] rslt;
        logic        err;
        logic        poke;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0;
    logic        r1_valid = 1'b0;
    logic [9:0]  r0_ctrl = '0;
    logic [9:0]  r1_ctrl = '0;
    logic [31:0] r0_src1 = '0;
    logic [31:0] r0_src2 = '0;
    logic [31:0] r1_src1 = '0;
    logic [31:0] r1_src2 = '0;
    logic        r0_ready, r1_ready;
    logic        r0_rvalid, r1_rvalid;
    logic [31:0] r0_rslt, r1_rslt;
    logic        r0_err, r1_err;
    logic        cfu_en;
    logic [9:0]  cfu_ctrl;
    logic [31:0] cfu_src1, cfu_src2;
    logic        cfu_stall;
    logic [31:0] cfu_rslt;

    int          stall_cfg = 0;
    int          stall_cnt = 0;
    logic [31:0] m_rslt = '0;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl [11];

    cfu_arbiter #(.RESET_LAST(1'b1), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready),
        .r0_ctrl_i(r0_ctrl), .r0_src1_i(r0_src1),
        .r0_src2_i(r0_src2), .r0_rvalid_o(r0_rvalid),
        .r0_rslt_o(r0_rslt), .r0_err_o(r0_err),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready),
        .r1_ctrl_i(r1_ctrl), .r1_src1_i(r1_src1),
        .r1_src2_i(r1_src2), .r1_rvalid_o(r1_rvalid),
        .r1_rslt_o(r1_rslt), .r1_err_o(r1_err),
        .cfu_en_o(cfu_en), .cfu_ctrl_o(cfu_ctrl),
        .cfu_src1_o(cfu_src1), .cfu_src2_o(cfu_src2),
        .cfu_stall_i(cfu_stall), .cfu_rslt_i(cfu_rslt)
    );

    always #5 clk = ~clk;

    // CFU model: result formed at the en pulse, stall high for
    // stall_cfg cycles starting the cycle after en.
    always @(posedge clk) begin
        if (cfu_en) begin
            stall_cnt <= stall_cfg;
            m_rslt <= (cfu_ctrl == 10'd1) ? cfu_src1 - cfu_src2
                                           : cfu_src1 + cfu_src2;
        end else if (stall_cnt > 0) begin
            stall_cnt <= stall_cnt - 1;
        end
    end

    assign cfu_stall = (stall_cnt != 0);
    assign cfu_rslt  = m_rslt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " flags"}, 32'({r0_ready, r1_ready, r0_rvalid,
            r1_rvalid, r0_err, r1_err, cfu_en}), 32'd0);
        chk({tag, " rslt0"}, r0_rslt, 32'd0);
        chk({tag, " rslt1"}, r1_rslt, 32'd0);
        chk({tag, " ctrl"}, 32'(cfu_ctrl), 32'd0);
        chk({tag, " src1"}, cfu_src1, 32'd0);
        chk({tag, " src2"}, cfu_src2, 32'd0);
    endtask

    task automatic run_row(input vec_t v, input int idx);
        string       t;
        logic [9:0]  ec;
        logic [31:0] e1, e2;
        int          n;
        logic        got, hold_ok, rdy_ok, other, en_ok;
        t  = $sformatf("row%0d", idx);
        ec = v.gnt ? v.c1 : v.c0;
        e1 = v.gnt ? v.a1 : v.a0;
        e2 = v.gnt ? v.b1 : v.b0;
        @(negedge clk);
        r0_valid = v.v0; r0_ctrl = v.c0;
        r0_src1 = v.a0; r0_src2 = v.b0;
        r1_valid = v.v1; r1_ctrl = v.c1;
        r1_src1 = v.a1; r1_src2 = v.b1;
        stall_cfg = v.stall;
        #1;
        chk({t, " ready0"}, 32'(r0_ready), 32'(v.gnt == 1'b0));
        chk({t, " ready1"}, 32'(r1_ready), 32'(v.gnt == 1'b1));
        @(posedge clk);
        #1;
        if (v.poke) begin
            r0_src1 = 32'hFFFF_FFFF; r0_src2 = 32'hFFFF_FFFF;
            r1_src1 = 32'hFFFF_FFFF; r1_src2 = 32'hFFFF_FFFF;
        end
        n = 0; got = 0; hold_ok = 1; rdy_ok = 1;
        other = 0; en_ok = 1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (cfu_en !== (n == 1)) en_ok = 0;
            if (cfu_ctrl !== ec || cfu_src1 !== e1 ||
                cfu_src2 !== e2) hold_ok = 0;
            if (r0_ready || r1_ready) rdy_ok = 0;
            if (v.gnt ? r0_rvalid : r1_rvalid) other = 1;
            got = v.gnt ? r1_rvalid : r0_rvalid;
        end
        chk({t, " latency"}, 32'(n), 32'(v.lat));
        chk({t, " rvalid"}, 32'(got), 32'd1);
        chk({t, " rslt"}, v.gnt ? r1_rslt : r0_rslt, v.rslt);
        chk({t, " err"}, 32'(v.gnt ? r1_err : r0_err), 32'(v.err));
        chk({t, " en pulse"}, 32'(en_ok), 32'd1);
        chk({t, " operand hold"}, 32'(hold_ok), 32'd1);
        chk({t, " ready low"}, 32'(rdy_ok), 32'd1);
        chk({t, " other rvalid"}, 32'(other), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 10'd0, 10'd0, 32'd5, 32'd7, 32'd0,
                    32'd0, 1, 4, 1'b0, 32'd12, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 10'd0, 10'd0, 32'd1, 32'd1, 32'd2,
                    32'd2, 0, 3, 1'b1, 32'd4, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 10'd0, 10'd0, 32'd1, 32'd1, 32'd2,
                    32'd2, 0, 3, 1'b0, 32'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 10'd0, 10'd0, 32'd1, 32'd1, 32'd2,
                    32'd2, 0, 3, 1'b1, 32'd4, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 10'd0, 10'd1, 32'd0, 32'd0, 32'd100,
                    32'd1, 2, 5, 1'b1, 32'd99, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 10'd0, 10'd0, 32'h10, 32'h20, 32'd0,
                    32'd0, 3, 6, 1'b0, 32'h30, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 10'd0, 10'd0, 32'hFFFF_FFFF, 32'd2,
                    32'd0, 32'd0, 10, 13, 1'b0, 32'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 10'd0, 10'd0, 32'h1234_0000,
                    32'h5678, 32'd0, 32'd0, 0, 3, 1'b0,
                    32'h1234_5678, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 10'd0, 10'd0, 32'd3, 32'd4, 32'd9,
                    32'd9, 0, 3, 1'b0, 32'd7, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 10'd0, 10'd0, 32'd0, 32'd0, 32'd6,
                    32'd6, 1000, 6, 1'b1, 32'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 10'd0, 10'd0, 32'd5, 32'd5, 32'd0,
                    32'd0, 1, 4, 1'b0, 32'd10, 1'b0, 1'b0};

        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #3;
        chk_zero("reset");
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_row(tbl[i], i);

        begin : async_reset
            logic seen;
            @(negedge clk);
            r1_valid = 1'b0;
            r0_valid = 1'b1; r0_ctrl = 10'd0;
            r0_src1 = 32'd1; r0_src2 = 32'd2;
            stall_cfg = 5;
            @(posedge clk);
            #1 r0_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("pre-reset in wait", 32'(cfu_stall), 32'd1);
            #2 rst = 1'b1;
            #1 chk_zero("async reset");
            @(negedge clk);
            rst = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (r0_rvalid || r1_rvalid || cfu_en) seen = 1'b1;
            end
            chk("aborted op silent", 32'(seen), 32'd0);
        end

        run_row(tbl[8], 8);
`ifdef CFU_ARB_TIMEOUT_EN
        run_row(tbl[9], 9);
`endif
        run_row(tbl[10], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_arbiter.md
Name: cfu_arbiter

Overview:
- Shares one multi-cycle CFU datapath between two requesters: port 0 is the CPU execute stage, port 1 is the debug/DMA test port.
- Round-robin grant, valid/ready request handshake, and a registered operand hold while the CFU works.
- One-cycle response pulse back to the granted requester.
- Sits between the requesters and the CFU instance, driving its en/ctrl/src inputs and sampling its stall/result outputs.

Parameters:
- RESET_LAST, 1, requester treated as "last granted" after reset (1 means port 0 wins the first tie).
- TIMEOUT_CYCLES, 256, maximum WAIT-state cycles before abort; used only with the optional feature; legal range 2..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- r0_valid_i  in  1  requester 0 request
- r0_ready_o  out  1  requester 0 request accepted this cycle
- r0_ctrl_i  in  10  requester 0 cfu_ctrl, {funct7, funct3}
- r0_src1_i  in  32  requester 0 operand 1
- r0_src2_i  in  32  requester 0 operand 2
- r0_rvalid_o  out  1  requester 0 response pulse
- r0_rslt_o  out  32  requester 0 result, valid with r0_rvalid_o
- r0_err_o  out  1  requester 0 timeout flag, valid with r0_rvalid_o
- r1_*  same set as r0_*, for requester 1
- cfu_en_o  out  1  one-cycle issue pulse to the CFU
- cfu_ctrl_o  out  10  held ctrl to the CFU
- cfu_src1_o  out  32  held operand 1 to the CFU
- cfu_src2_o  out  32  held operand 2 to the CFU
- cfu_stall_i  in  1  CFU busy
- cfu_rslt_i  in  32  CFU result

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; last = RESET_LAST.
  - All outputs are 0: ready, rvalid, rslt, err, cfu_en, cfu_ctrl, cfu_src.
  - An in-flight CFU result is discarded. The CFU itself is not reset; cfu_stall_i is ignored until the next ISSUE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant:
  - Grant goes to the only valid requester; if both are valid, to the requester that is not `last`.
  - rN_ready_o is combinational: high only for the granted requester, only in IDLE.
  - On handshake (valid & ready), latch ctrl/src1/src2 and the grant id, then go to ISSUE.
  - If no requester is valid, stay in IDLE.
- ISSUE:
  - cfu_en_o = 1 for exactly this cycle; cfu_ctrl/src1/src2_o carry the latched values.
  - Next state is WAIT.
- WAIT:
  - cfu_en_o = 0; operands are held stable.
  - Each cycle, if cfu_stall_i = 0: capture cfu_rslt_i and go to RESP.
  - If cfu_stall_i = 1: stay in WAIT.
  - The first WAIT cycle is the cycle after the en pulse. A CFU that never stalls completes in that cycle.
- RESP:
  - rN_rvalid_o = 1 and rN_rslt_o = captured result, for the granted requester only, for one cycle.
  - The other requester's rvalid stays 0.
  - last = granted id; next state is IDLE.
  - No grant is made in RESP. Ready is low in ISSUE, WAIT and RESP.
- rslt outputs hold their last value when rvalid is low. Bench checks the value only with rvalid.
- Latency, handshake cycle T to rvalid:
  - CFU with 1 stall cycle (stall high at T+2, low at T+3): rvalid at T+4.
  - Non-stalling CFU: rvalid at T+3.
  - Minimum spacing between handshakes is 4 cycles.
- Requesters may deassert valid before ready without penalty.
- Operands are sampled only at the handshake; later input changes are ignored.
- Simultaneous valid in IDLE alternates strictly. A single continuously valid requester is granted back-to-back with no bubble beyond the FSM.

Optional Feature:
- Macro: CFU_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears in ISSUE and increments each WAIT cycle with stall high.
  - When the counter reaches TIMEOUT_CYCLES, go to RESP with rslt = 0 and rN_err_o = 1 alongside rvalid.
  - The next ISSUE proceeds normally.
- Without the macro: no counter logic; rN_err_o is constant 0; WAIT is unbounded.

Test Plan:
- Reset, then r0 valid with ctrl=0, src1=5, src2=7, against the 1-stall adder CFU -> r0_ready=1 at T, cfu_en at T+1 with src 5/7, r0_rvalid at T+4 with rslt=12, r1_rvalid stays 0.
- Both valid continuously, r0 src1=1/src2=1 and r1 src1=2/src2=2 -> grants alternate r0, r1, r0, ...; results alternate 2, 4, ...; first grant goes to r0 (RESET_LAST=1).
- Change r0_src1_i to 0xFFFF_FFFF the cycle after the handshake -> cfu_src1_o keeps the latched value through WAIT; result unchanged.
- Model stall held high 10 cycles -> ready stays 0 throughout; rvalid comes 1 cycle after stall falls, with the CFU result.
- Assert rst_i asynchronously during WAIT -> all outputs 0 immediately; no rvalid for the aborted op; the next request completes normally.
- With CFU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, stall held high -> rvalid with rslt=0 and err=1 after 4 WAIT cycles; without the macro, err is never 1.
